// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word-aligned requests to instruction memory,
// buffers one fetched instruction for decode, and handles redirects. A request
// that was in flight when a redirect arrived is allowed to finish and its data
// is dropped (DISCARD), so no stale instruction ever reaches decode.
//
// Handshakes: imem_req/imem_ack -- a request is held with a stable imem_addr
// until the edge at which imem_ack=1, and each ack retires exactly one request.
// out_valid/out_ready -- an output is transferred at an edge where both are 1;
// while out_valid=1 and out_ready=0 every out_* signal holds its value.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic [31:0] redirect_aligned;
    logic [31:0] req_addr_plus4;

    // Low two bits of a redirect target are ignored; plain unsigned wrap on +4.
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
    assign req_addr_plus4   = req_addr + 32'd4;

    // Request is suppressed during reset so an ack then cannot match anything.
    assign imem_req  = !reset && (state != HOLD);
    assign imem_addr = req_addr;
    assign dbg_state = state;

    // Fetch state machine with registered output buffer; redirect wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            fetch_pc     <= RESET_PC;
            req_addr     <= RESET_PC;
            out_valid    <= 1'b0;
            out_instr    <= 32'd0;
            out_pc       <= 32'd0;
            out_pc_plus4 <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        out_valid <= 1'b0;
                        fetch_pc  <= redirect_aligned;
                        if (imem_ack) begin
                            req_addr <= redirect_aligned;
                            state    <= FETCH;
                        end else begin
                            // Keep req_addr: the memory still owns this request.
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        out_instr    <= imem_rdata;
                        out_pc       <= req_addr;
                        out_pc_plus4 <= req_addr_plus4;
                        out_valid    <= 1'b1;
                        fetch_pc     <= req_addr_plus4;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        out_valid <= 1'b0;
                        fetch_pc  <= redirect_aligned;
                        req_addr  <= redirect_aligned;
                        state     <= FETCH;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        req_addr  <= fetch_pc;
                        state     <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect_valid) begin
                        out_valid <= 1'b0;
                        fetch_pc  <= redirect_aligned;
                        if (imem_ack) begin
                            req_addr <= redirect_aligned;
                            state    <= FETCH;
                        end
                    end else if (imem_ack) begin
                        req_addr <= fetch_pc;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state     <= FETCH;
                    out_valid <= 1'b0;
                    req_addr  <= fetch_pc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one task per scenario, inline comparisons
// against hand-computed values, single summary line at the end.
module tb_instr_fetch;

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .dbg_state      (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; all driving and sampling happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Zero-wait ack of the current request, then one HOLD cycle with out_ready=1.
    task automatic complete_fetch(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        imem_ack       = 1'b1;
        imem_rdata     = 32'hBAD0_BAD0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b expected 0", imem_req);
        end
        checks++;
        if ({out_valid, out_instr, out_pc, out_pc_plus4} !== 97'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b i=%h pc=%h p4=%h expected all 0",
                     out_valid, out_instr, out_pc, out_pc_plus4);
        end
        imem_ack = 1'b0;
        reset    = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=00000000",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 32'(k) * 32'd4;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== a) begin
                errors++;
                $display("FAIL zw_req%0d: got req=%b addr=%h expected req=1 addr=%h",
                         k, imem_req, imem_addr, a);
            end
            imem_ack   = 1'b1;
            imem_rdata = 32'h1000_0000 + a;
            tick();
            imem_ack = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== a || out_pc_plus4 !== a + 32'd4 ||
                out_instr !== 32'h1000_0000 + a || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL zw_out%0d: got v=%b pc=%h p4=%h i=%h req=%b expected v=1 pc=%h p4=%h i=%h req=0",
                         k, out_valid, out_pc, out_pc_plus4, out_instr, imem_req,
                         a, a + 32'd4, 32'h1000_0000 + a);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL zw_pulse%0d: got out_valid=%b expected 0", k, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        out_ready  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h8C01_0004;
        tick();
        imem_ack = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_instr !== 32'h8C01_0004 || out_pc !== 32'h0 ||
                out_pc_plus4 !== 32'h4 || imem_req !== 1'b0 || dbg_state !== ST_HOLD) begin
                errors++;
                $display("FAIL stall_c%0d: got v=%b i=%h pc=%h p4=%h req=%b st=%0d expected v=1 i=8c010004 pc=0 p4=4 req=0 st=1",
                         c, out_valid, out_instr, out_pc, out_pc_plus4, imem_req, dbg_state);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got req=%b addr=%h v=%b expected req=1 addr=4 v=0",
                     imem_req, imem_addr, out_valid);
        end
    endtask

    task automatic test_redirect_discard();
        // Currently requesting 0x4; retire it so the next request is 0x8.
        complete_fetch(32'h1111_0004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || dbg_state !== ST_DISCARD ||
                out_valid !== 1'b0) begin
                errors++;
                $display("FAIL disc_hold%0d: got req=%b addr=%h st=%0d v=%b expected req=1 addr=8 st=2 v=0",
                         c, imem_req, imem_addr, dbg_state, out_valid);
            end
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0008;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL disc_drop: got v=%b req=%b addr=%h expected v=0 req=1 addr=100",
                     out_valid, imem_req, imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_0100;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h2222_0100 ||
            out_pc_plus4 !== 32'h104) begin
            errors++;
            $display("FAIL disc_next: got v=%b pc=%h i=%h p4=%h expected v=1 pc=100 i=22220100 p4=104",
                     out_valid, out_pc, out_instr, out_pc_plus4);
        end
    endtask

    task automatic test_redirect_with_ack();
        apply_reset();
        complete_fetch(32'h0);
        complete_fetch(32'h4);
        complete_fetch(32'h8);
        checks++;
        if (imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL ack_redir_pre: got addr=%h expected 0000000c", imem_addr);
        end
        imem_ack       = 1'b1;
        imem_rdata     = 32'hDEAD_000C;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40 ||
            dbg_state !== ST_FETCH) begin
            errors++;
            $display("FAIL ack_redir_drop: got v=%b req=%b addr=%h st=%0d expected v=0 req=1 addr=40 st=0",
                     out_valid, imem_req, imem_addr, dbg_state);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_0040;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h3333_0040) begin
            errors++;
            $display("FAIL ack_redir_next: got v=%b pc=%h i=%h expected v=1 pc=40 i=33330040",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_wrap();
        // Sitting in HOLD with the 0x40 instruction; redirect from HOLD.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req: got v=%b req=%b addr=%h expected v=0 req=1 addr=fffffffc",
                     out_valid, imem_req, imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h4444_FFFC;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_out: got v=%b pc=%h p4=%h expected v=1 pc=fffffffc p4=0",
                     out_valid, out_pc, out_pc_plus4);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next: got req=%b addr=%h expected req=1 addr=0",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_in_discard();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (dbg_state !== ST_DISCARD) begin
            errors++;
            $display("FAIL rst_disc_pre: got st=%0d expected 2", dbg_state);
        end
        reset = 1'b1;
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0000;
        tick();
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_disc_during: got req=%b v=%b expected req=0 v=0",
                     imem_req, out_valid);
        end
        imem_ack = 1'b0;
        reset    = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || dbg_state !== ST_FETCH) begin
            errors++;
            $display("FAIL rst_disc_after: got req=%b addr=%h st=%0d expected req=1 addr=0 st=0",
                     imem_req, imem_addr, dbg_state);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_disc_wait: got v=%b addr=%h expected v=0 addr=0",
                     out_valid, imem_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_0000;
        tick();
        imem_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h5555_0000) begin
            errors++;
            $display("FAIL rst_disc_first: got v=%b pc=%h i=%h expected v=1 pc=0 i=55550000",
                     out_valid, out_pc, out_instr);
        end
    endtask

    // Scenario sequence and final report.
    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_discard();
        test_redirect_with_ack();
        test_wrap();
        test_reset_in_discard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
